// File: rtl/fetch_exec_controller_pkg.sv
// fetch_exec_controller_pkg: opcodes, state encoding, bus/ALU codes and control-word decode
package fetch_exec_controller_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_MEM  = 3'd2;
    localparam logic [2:0] BUS_IMM  = 3'd3;
    localparam logic [2:0] BUS_ALU  = 3'd4;
    localparam logic [2:0] BUS_REG  = 3'd5;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_ADDR,
        S_F_READ,
        S_F_LOAD,
        S_DECODE,
        S_EXEC,
        S_M_ADDR,
        S_M_ACC,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [2:0] bus_sel;
        logic       mar_en;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_en;
        logic       pc_inc;
        logic       pc_load;
        logic       reg_wr;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    // Control word for a state; op is the opcode latched at DECODE.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_F_ADDR: begin
                c.bus_sel = BUS_PC;
                c.mar_en  = 1'b1;
            end
            S_F_READ: c.mem_rd = 1'b1;
            S_F_LOAD: begin
                c.bus_sel = BUS_MEM;
                c.ir_en   = 1'b1;
                c.pc_inc  = 1'b1;
            end
            S_EXEC: begin
                c.bus_sel = (op == OP_ADD || op == OP_SUB) ? BUS_ALU : BUS_IMM;
                c.alu_op  = op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : ALU_PASS;
                c.reg_wr  = op inside {OP_LDI, OP_ADD, OP_SUB};
                c.pc_load = op inside {OP_JMP, OP_JZ};
            end
            S_M_ADDR: begin
                c.bus_sel = BUS_IMM;
                c.mar_en  = 1'b1;
            end
            S_M_ACC: begin
                c.mem_rd  = op == OP_LD;
                c.mem_wr  = op == OP_ST;
                c.bus_sel = op == OP_ST ? BUS_REG : BUS_NONE;
            end
            S_WB: begin
                c.bus_sel = BUS_MEM;
                c.reg_wr  = 1'b1;
            end
            S_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fetch_exec_controller_mem_wait_timer.sv
// fetch_exec_controller_mem_wait_timer: counts memory wait cycles, flags timeout
module fetch_exec_controller_mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 8'd1;
    end

    // Fires on the LIMIT-th consecutive unanswered wait cycle.
    assign expired = en && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/fetch_exec_controller.sv
// fetch_exec_controller: Moore FSM sequencing fetch, decode and execute of the 16-bit CPU datapath
module fetch_exec_controller
    import fetch_exec_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        zero_flag,
    input  logic        mem_ready,
    input  logic        run,
    output logic [2:0]  bus_sel,
    output logic        mar_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        ir_en,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        reg_wr,
    output logic [1:0]  alu_op,
    output logic        halted,
    output logic        fault
);

    state_t     state, state_n;
    logic [3:0] op, op_n;
    logic       fault_n;
    logic       waiting;
    logic       expired;
    ctrl_t      ctrl;
    logic       unused_ir;

    assign unused_ir = ^ir[11:0];
    assign waiting   = state inside {S_F_READ, S_M_ACC};

    fetch_exec_controller_mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!waiting),
        .en      (waiting && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        op_n    = op;
        fault_n = fault;
        case (state)
            S_IDLE:   state_n = run ? S_F_ADDR : S_IDLE;
            S_F_ADDR: state_n = S_F_READ;
            S_F_READ: begin
                if (mem_ready)
                    state_n = S_F_LOAD;
                else if (expired) begin
                    state_n = S_HALT;
                    fault_n = 1'b1;
                end
            end
            S_F_LOAD: state_n = S_DECODE;
            S_DECODE: begin
                op_n = ir[15:12];
                case (ir[15:12])
                    OP_NOP:                         state_n = S_F_ADDR;
                    OP_LDI, OP_ADD, OP_SUB, OP_JMP: state_n = S_EXEC;
                    OP_LD, OP_ST:                   state_n = S_M_ADDR;
                    OP_JZ:                          state_n = zero_flag ? S_EXEC : S_F_ADDR;
                    OP_HALT:                        state_n = S_HALT;
                    default: begin
                        state_n = S_HALT;
                        fault_n = 1'b1;
                    end
                endcase
            end
            S_EXEC:   state_n = S_F_ADDR;
            S_M_ADDR: state_n = S_M_ACC;
            S_M_ACC: begin
                if (mem_ready)
                    state_n = op == OP_LD ? S_WB : S_F_ADDR;
                else if (expired) begin
                    state_n = S_HALT;
                    fault_n = 1'b1;
                end
            end
            S_WB:     state_n = S_F_ADDR;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_IDLE;
        endcase
    end

    // Control word is decoded from the next state so outputs are registered yet aligned with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op    <= OP_NOP;
            fault <= 1'b0;
            ctrl  <= '0;
        end else begin
            state <= state_n;
            op    <= op_n;
            fault <= fault_n;
            ctrl  <= ctrl_of(state_n, op_n);
        end
    end

    assign bus_sel = ctrl.bus_sel;
    assign mar_en  = ctrl.mar_en;
    assign mem_rd  = ctrl.mem_rd;
    assign mem_wr  = ctrl.mem_wr;
    assign ir_en   = ctrl.ir_en;
    assign pc_inc  = ctrl.pc_inc;
    assign pc_load = ctrl.pc_load;
    assign reg_wr  = ctrl.reg_wr;
    assign alu_op  = ctrl.alu_op;
    assign halted  = ctrl.halted;

endmodule
